fp_add_seq_ctrl: RTL and testbench

Sequencing controller for the 37-bit extended-format FP adder datapath: 1 sign, 8 exponent [35:28], 28 significand [27:0] (hidden + 23 fraction + guard/round/sticky + spare).
- Accepts one operand pair per transaction over a valid/ready handshake.
- Drives the 2-bit exponent-compare path select into the operand router, and steps alignment, add and normalization with per-cycle enables.
- Tracks the result exponent and presents a handshaked completion.

---
 rtl/fp_add_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fp_add_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq_ctrl.sv
// fp_add_seq_ctrl: sequencing controller for the 37-bit extended-format FP
// adder datapath (1 sign, 8 exponent, 28 significand bits).
//
// Flow: IDLE -> CMP -> [ALIGN] -> ADD -> NORM -> DONE -> IDLE
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE, and res_exp/ovf/unf/res_zero are held stable until the
// out_valid & out_ready edge. Neither side may withdraw once it asserts valid.
//
// Optional feature macro: FP_ADD_SEQ_FAST_ALIGN_EN
//   defined   -> alignment is a single ALIGN cycle, align_amt = shift count
//                (the datapath uses a barrel shifter)
//   undefined -> one-bit-per-cycle alignment, align_amt tied to 0
//
// All datapath enables (shift_en, add_en, norm_shr, norm_shl) are registered
// from the next-state decision, so they are glitch-free and mutually
// exclusive. dbg_state exposes the FSM state for checkers.

module fp_add_seq_ctrl #(
   parameter int EXP_W = 8,
   parameter int SIG_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EXP_W-1:0] exp_a,
   input  logic [EXP_W-1:0] exp_b,
   output logic [1:0]       e_sel,
   output logic             shift_en,
   output logic [4:0]       align_amt,
   output logic             add_en,
   input  logic             sum_carry,
   input  logic             sum_msb,
   input  logic             sum_zero,
   output logic             norm_shr,
   output logic             norm_shl,
   output logic [EXP_W-1:0] res_exp,
   output logic             ovf,
   output logic             unf,
   output logic             res_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       dbg_state
);

   // Largest alignment / normalization step count.
   localparam logic [4:0]       C_MAX_CNT   = 5'(SIG_W - 1);
   localparam logic [EXP_W-1:0] C_MAX_DIFF  = EXP_W'(SIG_W - 1);
   localparam logic [EXP_W-1:0] C_EXP_MAX   = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] C_EXP_MAXM1 = C_EXP_MAX - 1'b1;

   // Router select encodings.
   localparam logic [1:0] C_SEL_EQ = 2'b00;
   localparam logic [1:0] C_SEL_A  = 2'b01;
   localparam logic [1:0] C_SEL_B  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMP   = 3'd1,
      S_ALIGN = 3'd2,
      S_ADD   = 3'd3,
      S_NORM  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state, w_state_nx;
   logic [EXP_W-1:0] r_exp_a, w_exp_a_nx;
   logic [EXP_W-1:0] r_exp_b, w_exp_b_nx;
   logic [4:0]       r_cnt, w_cnt_nx;
   logic [4:0]       r_ncnt, w_ncnt_nx;
   logic [1:0]       r_e_sel, w_e_sel_nx;
   logic [EXP_W-1:0] r_res_exp, w_res_exp_nx;
   logic             r_ovf, w_ovf_nx;
   logic             r_unf, w_unf_nx;
   logic             r_zero, w_zero_nx;
   logic             r_shift_en, w_shift_en_nx;
   logic             r_add_en, w_add_en_nx;
   logic             r_shr, w_shr_nx;
   logic             r_shl, w_shl_nx;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
   logic [4:0]       r_align_amt, w_align_amt_nx;
`endif

   // Exponent difference of the latched operands, saturated to the longest
   // useful shift; bits shifted beyond that only feed the datapath sticky.
   logic             w_a_gt_b;
   logic [EXP_W-1:0] w_diff;
   logic [4:0]       w_diff_sat;

   assign w_a_gt_b   = (r_exp_a > r_exp_b);
   assign w_diff     = w_a_gt_b ? (r_exp_a - r_exp_b) : (r_exp_b - r_exp_a);
   assign w_diff_sat = (w_diff > C_MAX_DIFF) ? C_MAX_CNT : w_diff[4:0];

   // Next-state and next-output decision; every target defaults to hold/idle.
   always_comb begin
      w_state_nx    = r_state;
      w_exp_a_nx    = r_exp_a;
      w_exp_b_nx    = r_exp_b;
      w_cnt_nx      = r_cnt;
      w_ncnt_nx     = r_ncnt;
      w_e_sel_nx    = r_e_sel;
      w_res_exp_nx  = r_res_exp;
      w_ovf_nx      = r_ovf;
      w_unf_nx      = r_unf;
      w_zero_nx     = r_zero;
      w_shift_en_nx = 1'b0;
      w_add_en_nx   = 1'b0;
      w_shr_nx      = 1'b0;
      w_shl_nx      = 1'b0;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
      w_align_amt_nx = 5'd0;
`endif
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_exp_a_nx = exp_a;
               w_exp_b_nx = exp_b;
               // Select is decided on the accept edge so it is already valid
               // throughout CMP and stays put until DONE is left.
               if (exp_a == exp_b)     w_e_sel_nx = C_SEL_EQ;
               else if (exp_a > exp_b) w_e_sel_nx = C_SEL_A;
               else                    w_e_sel_nx = C_SEL_B;
               w_state_nx = S_CMP;
            end
         end

         S_CMP: begin
            w_res_exp_nx = w_a_gt_b ? r_exp_a : r_exp_b;
            w_cnt_nx     = w_diff_sat;
            if (w_diff_sat == 5'd0) begin
               w_add_en_nx = 1'b1;
               w_state_nx  = S_ADD;
            end else begin
               w_shift_en_nx = 1'b1;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
               w_align_amt_nx = w_diff_sat;
`endif
               w_state_nx = S_ALIGN;
            end
         end

         S_ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
            // Whole shift done by the barrel shifter in this one cycle.
            w_cnt_nx    = 5'd0;
            w_add_en_nx = 1'b1;
            w_state_nx  = S_ADD;
`else
            // One bit per cycle; the last shift cycle is the one with cnt == 1.
            w_cnt_nx = r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
               w_add_en_nx = 1'b1;
               w_state_nx  = S_ADD;
            end else begin
               w_shift_en_nx = 1'b1;
            end
`endif
         end

         S_ADD: begin
            w_ncnt_nx  = 5'd0;
            w_state_nx = S_NORM;
         end

         S_NORM: begin
            if (sum_zero) begin
               w_zero_nx    = 1'b1;
               w_res_exp_nx = '0;
               w_state_nx   = S_DONE;
            end else if (sum_carry && (r_ncnt == 5'd0)) begin
               // Carry can only appear straight out of the adder.
               w_shr_nx = 1'b1;
               if (r_res_exp >= C_EXP_MAXM1) begin
                  w_res_exp_nx = C_EXP_MAX;
                  w_ovf_nx     = 1'b1;
               end else begin
                  w_res_exp_nx = r_res_exp + 1'b1;
               end
               w_state_nx = S_DONE;
            end else if (sum_msb) begin
               w_state_nx = S_DONE;
            end else if (r_res_exp == '0) begin
               // No exponent left to borrow: stop denormalized.
               w_unf_nx   = 1'b1;
               w_state_nx = S_DONE;
            end else begin
               w_shl_nx     = 1'b1;
               w_res_exp_nx = r_res_exp - 1'b1;
               w_ncnt_nx    = r_ncnt + 5'd1;
               if (r_ncnt == (C_MAX_CNT - 5'd1)) begin
                  w_state_nx = S_DONE;
               end
            end
         end

         S_DONE: begin
            if (out_ready) begin
               w_e_sel_nx   = C_SEL_EQ;
               w_res_exp_nx = '0;
               w_ovf_nx     = 1'b0;
               w_unf_nx     = 1'b0;
               w_zero_nx    = 1'b0;
               w_cnt_nx     = 5'd0;
               w_ncnt_nx    = 5'd0;
               w_state_nx   = S_IDLE;
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_exp_a    <= '0;
         r_exp_b    <= '0;
         r_cnt      <= 5'd0;
         r_ncnt     <= 5'd0;
         r_e_sel    <= C_SEL_EQ;
         r_res_exp  <= '0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_zero     <= 1'b0;
         r_shift_en <= 1'b0;
         r_add_en   <= 1'b0;
         r_shr      <= 1'b0;
         r_shl      <= 1'b0;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
         r_align_amt <= 5'd0;
`endif
      end else begin
         r_state    <= w_state_nx;
         r_exp_a    <= w_exp_a_nx;
         r_exp_b    <= w_exp_b_nx;
         r_cnt      <= w_cnt_nx;
         r_ncnt     <= w_ncnt_nx;
         r_e_sel    <= w_e_sel_nx;
         r_res_exp  <= w_res_exp_nx;
         r_ovf      <= w_ovf_nx;
         r_unf      <= w_unf_nx;
         r_zero     <= w_zero_nx;
         r_shift_en <= w_shift_en_nx;
         r_add_en   <= w_add_en_nx;
         r_shr      <= w_shr_nx;
         r_shl      <= w_shl_nx;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
         r_align_amt <= w_align_amt_nx;
`endif
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign e_sel     = r_e_sel;
   assign shift_en  = r_shift_en;
   assign add_en    = r_add_en;
   assign norm_shr  = r_shr;
   assign norm_shl  = r_shl;
   assign res_exp   = r_res_exp;
   assign ovf       = r_ovf;
   assign unf       = r_unf;
   assign res_zero  = r_zero;
   assign dbg_state = r_state;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
   assign align_amt = r_align_amt;
`else
   assign align_amt = 5'd0;
`endif

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Bench for fp_add_seq_ctrl: directed transactions with hand-computed
// results pushed into a scoreboard queue; a monitor on the falling edge pops
// and compares when out_valid appears. A small datapath stub drives sum_msb
// per NORM cycle. Latency is counted as in the plan: cycle N is the Nth
// rising edge after the accept edge at which out_valid is sampled high.
module tb_fp_add_seq_ctrl;

  `ifdef FP_ADD_SEQ_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
  `else
  localparam bit FAST = 1'b0;
  `endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'h00;
  logic [1:0] e_sel;
  logic       shift_en;
  logic [4:0] align_amt;
  logic       add_en;
  logic       sum_carry = 1'b0;
  logic       sum_msb = 1'b0;
  logic       sum_zero = 1'b0;
  logic       norm_shr;
  logic       norm_shl;
  logic [7:0] res_exp;
  logic       ovf;
  logic       unf;
  logic       res_zero;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] dbg_state;

  fp_add_seq_ctrl #(.EXP_W(8), .SIG_W(28)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .e_sel(e_sel), .shift_en(shift_en),
    .align_amt(align_amt), .add_en(add_en), .sum_carry(sum_carry),
    .sum_msb(sum_msb), .sum_zero(sum_zero), .norm_shr(norm_shr),
    .norm_shl(norm_shl), .res_exp(res_exp), .ovf(ovf), .unf(unf),
    .res_zero(res_zero), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    string      name;
    logic [1:0] e_sel;
    logic [7:0] res_exp;
    logic       ovf;
    logic       unf;
    logic       rz;
    int         n_shift;
    int         amt;
    int         n_shr;
    int         n_shl;
    int         lat;
    int         hold;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   k_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- datapath stub ----------------
  // sum_msb stays low for the first k_low NORM cycles of a transaction.
  bit dp_act = 1'b0;
  int nidx = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_act = 1'b0;
    end else if (add_en) begin
      dp_act = 1'b1;
      nidx = 0;
      sum_msb = 1'b0;
    end else if (dp_act) begin
      nidx++;
      sum_msb = (nidx > k_low);
      if (out_valid) dp_act = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  bit         in_ov = 1'b0;
  int         wcnt = 0;
  int         a_shift = 0, a_amt = 0, a_add = 0, a_shr = 0, a_shl = 0;
  logic [7:0] cap_exp;
  logic [3:0] cap_flags;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_ov = 1'b0;
      out_ready = 1'b0;
      a_shift = 0; a_amt = 0; a_add = 0; a_shr = 0; a_shl = 0;
    end else begin
      a_shift += int'(shift_en);
      a_add   += int'(add_en);
      a_shr   += int'(norm_shr);
      a_shl   += int'(norm_shl);
      if (int'(align_amt) > a_amt) a_amt = int'(align_amt);
      if (out_valid) begin
        if (!in_ov) begin
          in_ov = 1'b1;
          wcnt = 0;
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 1, 0);
            cur.hold = 0;
          end else begin
            cur = exp_q[0];
            check({cur.name, "_e_sel"},    int'(e_sel),    int'(cur.e_sel));
            check({cur.name, "_res_exp"},  int'(res_exp),  int'(cur.res_exp));
            check({cur.name, "_ovf"},      int'(ovf),      int'(cur.ovf));
            check({cur.name, "_unf"},      int'(unf),      int'(cur.unf));
            check({cur.name, "_res_zero"}, int'(res_zero), int'(cur.rz));
            check({cur.name, "_shift_cycles"}, a_shift, cur.n_shift);
            check({cur.name, "_align_amt"},    a_amt,   cur.amt);
            check({cur.name, "_add_pulses"},   a_add,   1);
            check({cur.name, "_shr_pulses"},   a_shr,   cur.n_shr);
            check({cur.name, "_shl_pulses"},   a_shl,   cur.n_shl);
            check({cur.name, "_latency"},      cyc - cur.acc_cyc + 1, cur.lat);
          end
          cap_exp = res_exp;
          cap_flags = {e_sel, ovf, unf} ^ {2'b00, 1'b0, res_zero};
        end else begin
          check({cur.name, "_hold_res_exp"}, int'(res_exp), int'(cap_exp));
          check({cur.name, "_hold_flags"},
                int'({e_sel, ovf, unf} ^ {2'b00, 1'b0, res_zero}), int'(cap_flags));
          check({cur.name, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = (wcnt >= cur.hold);
        wcnt++;
      end else if (in_ov) begin
        in_ov = 1'b0;
        out_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        n_done++;
        a_shift = 0; a_amt = 0; a_add = 0; a_shr = 0; a_shl = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic z, input int kl,
                       input logic [1:0] es, input logic [7:0] re,
                       input logic ov, input logic un, input logic rz,
                       input int nsh, input int amt, input int shr, input int shl,
                       input int lat, input int hold);
    exp_t e;
    int   d0;
    bit   got;
    @(negedge clk);
    if (in_ready !== 1'b1) begin
      check({nm, "_idle_before_issue"}, int'(in_ready), 1);
      return;
    end
    exp_a = a; exp_b = b; sum_carry = c; sum_zero = z; k_low = kl;
    in_valid = 1'b1;
    e.name = nm; e.e_sel = es; e.res_exp = re; e.ovf = ov; e.unf = un; e.rz = rz;
    e.n_shift = nsh; e.amt = amt; e.n_shr = shr; e.n_shl = shl; e.lat = lat;
    e.hold = hold; e.acc_cyc = cyc + 1;
    d0 = n_done;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (n_done > d0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check({nm, "_completion_timeout"}, 0, 1);
      exp_q.delete();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    #1;
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_enables",   int'({shift_en, add_en, norm_shr, norm_shl}), 0);
    check("reset_res",       int'({e_sel, ovf, unf, res_zero, res_exp}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //    name        a      b     c  z  kl  e_sel  res    ov un rz  shifts          amt             shr shl lat               hold
    issue("t1_eq",    8'h80, 8'h80, 0, 0, 0, 2'b00, 8'h80, 0, 0, 0, 0,              0,              0,  0,  4,                0);
    issue("t2_a_gt",  8'h85, 8'h80, 0, 0, 0, 2'b01, 8'h85, 0, 0, 0, FAST ? 1 : 5,   FAST ? 5 : 0,   0,  0,  FAST ? 5 : 9,     0);
    issue("t3_b_big", 8'h10, 8'h40, 0, 0, 0, 2'b10, 8'h40, 0, 0, 0, FAST ? 1 : 27,  FAST ? 27 : 0,  0,  0,  FAST ? 5 : 31,    0);
    issue("t4_ovf",   8'hFE, 8'hFE, 1, 0, 0, 2'b00, 8'hFF, 1, 0, 0, 0,              0,              1,  0,  4,                3);
    issue("t5_unf",   8'h02, 8'h02, 0, 0, 4, 2'b00, 8'h00, 0, 1, 0, 0,              0,              0,  2,  6,                0);
    issue("t6_zero",  8'h30, 8'h30, 0, 1, 0, 2'b00, 8'h00, 0, 0, 1, 0,              0,              0,  0,  4,                0);
    issue("t7_shl2",  8'h80, 8'h80, 0, 0, 2, 2'b00, 8'h7E, 0, 0, 0, 0,              0,              0,  2,  6,                0);
    issue("t8_carry", 8'h80, 8'h81, 1, 0, 0, 2'b10, 8'h82, 0, 0, 0, 1,              FAST ? 1 : 0,   1,  0,  5,                1);

    // Reset during alignment: the transaction is dropped without a result.
    @(negedge clk);
    exp_a = 8'h85; exp_b = 8'h80; sum_carry = 1'b0; sum_zero = 1'b0; k_low = 0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_shift_en_in_align", int'(shift_en), 1);
    rst_n = 1'b0;
    #1;
    check("abort_enables_cleared", int'({shift_en, add_en, norm_shr, norm_shl}), 0);
    check("abort_out_valid",       int'(out_valid), 0);
    check("abort_in_ready",        int'(in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_result", int'(out_valid), 0);
    end
    check("abort_in_ready_after", int'(in_ready), 1);

    issue("t9_after", 8'h80, 8'h80, 0, 0, 0, 2'b00, 8'h80, 0, 0, 0, 0, 0, 0, 0, 4, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit as a last resort.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 20000);
    $fatal(1);
  end

endmodule
